// File: rtl/platform_spawner.sv
// Seeds the platform LFSR on game start, samples one value per rnd_tick high period,
// filters off-screen and too-close samples, and queues screen x-positions in a show-ahead FIFO.
module platform_spawner #(
   parameter int DEPTH    = 4,
   parameter int MAX_X    = 448,
   parameter int X_OFFSET = 64,
   parameter int MIN_SEP  = 32
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       start,
   output logic [8:0] seed,
   output logic       seed_load,
   input  logic [8:0] rnd,
   input  logic       rnd_tick,
   input  logic       pop,
   output logic       plat_valid,
   output logic [9:0] plat_x,
   output logic [3:0] count,
   output logic       reject
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [9:0] MAX_X_W   = 10'(MAX_X);
   localparam logic [9:0] X_OFF_W   = 10'(X_OFFSET);
   localparam logic [9:0] MIN_SEP_W = 10'(MIN_SEP);
   localparam logic [3:0] DEPTH_W   = 4'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;

   state_t          state, state_nx;
   logic [8:0]      ent_cnt;
   logic            tick_d;
   logic            has_last;
   logic [8:0]      last;
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [9:0]      mem [DEPTH];

   logic            restart, run_cyc, edge_hit, pop_ok;
   logic            in_range, sep_ok, room, accept;
   logic [9:0]      diff;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SEED;
         SEED:    state_nx = RUN;
         RUN:     if (start) state_nx = SEED;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      seed_load  = (state == SEED);
      plat_valid = (count != 4'd0);
      plat_x     = plat_valid ? mem[rd_ptr] : 10'd0;
   end

   // A start in RUN preempts both sampling and popping for that cycle.
   always_comb begin
      restart  = start && (state != SEED);
      run_cyc  = (state == RUN) && !start;
      edge_hit = run_cyc && rnd_tick && !tick_d;
      pop_ok   = run_cyc && pop && (count != 4'd0);
      diff     = (rnd >= last) ? ({1'b0, rnd} - {1'b0, last}) : ({1'b0, last} - {1'b0, rnd});
      in_range = ({1'b0, rnd} <= MAX_X_W);
      sep_ok   = !has_last || (diff >= MIN_SEP_W);
      room     = (count < DEPTH_W) || pop_ok;
      accept   = edge_hit && in_range && sep_ok && room;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ent_cnt <= 9'd0;
         seed    <= 9'd0;
         tick_d  <= 1'b0;
         reject  <= 1'b0;
      end else begin
         ent_cnt <= ent_cnt + 9'd1;
         reject  <= edge_hit && !accept;
         // Edge detector restarts after a seed so the first RUN cycle can sample.
         tick_d  <= (state == SEED) ? 1'b0 : rnd_tick;
         // 0x1FF is the LFSR lock-up state and must never be loaded.
         if (restart) seed <= (ent_cnt == 9'h1FF) ? 9'h001 : ent_cnt;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= 4'd0;
         has_last <= 1'b0;
         last     <= 9'd0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 10'd0;
      end else if (restart) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= 4'd0;
         has_last <= 1'b0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= X_OFF_W + {1'b0, rnd};
            wr_ptr      <= wr_ptr + 1'b1;
            last        <= rnd;
            has_last    <= 1'b1;
         end
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {3'd0, accept} - {3'd0, pop_ok};
      end
   end

endmodule

// File: tb/tb_platform_spawner.sv
// Bench for platform_spawner: vector table, directed corner sequences and random traffic
// compared against a queue-based reference model.
module tb_platform_spawner;

   localparam int DEPTH = 4, MAX_X = 448, X_OFFSET = 64, MIN_SEP = 32;

   logic       Clk = 1'b0, Reset = 1'b1, start = 1'b0, rnd_tick = 1'b0, pop = 1'b0;
   logic [8:0] rnd = 9'd0;
   logic [8:0] seed;
   logic       seed_load, plat_valid, reject;
   logic [9:0] plat_x;
   logic [3:0] count;

   platform_spawner #(.DEPTH(DEPTH), .MAX_X(MAX_X), .X_OFFSET(X_OFFSET), .MIN_SEP(MIN_SEP)) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .seed(seed), .seed_load(seed_load),
      .rnd(rnd), .rnd_tick(rnd_tick), .pop(pop), .plat_valid(plat_valid),
      .plat_x(plat_x), .count(count), .reject(reject)
   );

   always #5 Clk = ~Clk;

   int checks = 0, failures = 0;

   // reference model: mode 0=idle 1=seeding 2=running
   int m_mode, m_seed, m_last, m_cnt;
   int q[$];
   bit m_has, m_prev, m_rej;

   typedef struct {bit st; bit rt; int r; bit p; int c; int rej; int x;} vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_seed = 0; m_last = 0; m_cnt = 0;
      q.delete();
      m_has = 0; m_prev = 0; m_rej = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".seed"}, 32'(seed), 0);
      chk({tag, ".seed_load"}, 32'(seed_load), 0);
      chk({tag, ".plat_valid"}, 32'(plat_valid), 0);
      chk({tag, ".plat_x"}, 32'(plat_x), 0);
      chk({tag, ".count"}, 32'(count), 0);
      chk({tag, ".reject"}, 32'(reject), 0);
   endtask

   // Drive one cycle of inputs, advance the model, compare at the following falling edge.
   task automatic cyc(input bit st, input bit rt, input int r, input bit p);
      bit e, ok;
      int d;
      start = st; rnd_tick = rt; rnd = r[8:0]; pop = p;
      m_rej = 0;
      if (st && m_mode != 1) begin
         m_seed = (m_cnt == 511) ? 1 : m_cnt;
         q.delete();
         m_has  = 0;
         m_mode = 1;
         m_prev = rt;
      end else if (m_mode == 1) begin
         m_mode = 2;
         m_prev = 0;
      end else begin
         e = (m_mode == 2) && rt && !m_prev;
         m_prev = rt;
         if (m_mode == 2) begin
            d  = (r > m_last) ? r - m_last : m_last - r;
            ok = (r <= MAX_X) && (!m_has || d >= MIN_SEP) &&
                 (q.size() < DEPTH || (p && q.size() > 0));
            if (p && q.size() > 0) void'(q.pop_front());
            if (e) begin
               if (ok) begin q.push_back(X_OFFSET + r); m_last = r; m_has = 1; end
               else m_rej = 1;
            end
         end
      end
      m_cnt = (m_cnt + 1) % 512;
      @(negedge Clk);
      chk("m.seed_load", 32'(seed_load), 32'(m_mode == 1));
      chk("m.seed", 32'(seed), m_seed);
      chk("m.count", 32'(count), q.size());
      chk("m.plat_valid", 32'(plat_valid), 32'(q.size() > 0));
      chk("m.plat_x", 32'(plat_x), (q.size() > 0) ? q[0] : 0);
      chk("m.reject", 32'(reject), 32'(m_rej));
   endtask

   task automatic add(input bit st, input bit rt, input int r, input bit p,
                      input int c, input int rej, input int x);
      vec_t v;
      v.st = st; v.rt = rt; v.r = r; v.p = p; v.c = c; v.rej = rej; v.x = x;
      tbl.push_back(v);
   endtask

   initial begin
      bit rt;
      model_reset();
      repeat (2) @(negedge Clk);
      chk_zero("reset");
      Reset = 1'b0;

      // seed captured at counter 0x025
      repeat (37) cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("seed_025.load", 32'(seed_load), 1);
      chk("seed_025.val", 32'(seed), 32'h025);
      chk("seed_025.count", 32'(count), 0);
      cyc(0, 0, 0, 0);
      chk("seed_025.load_off", 32'(seed_load), 0);
      chk("seed_025.hold", 32'(seed), 32'h025);

      // lock-up substitution
      while (m_cnt != 511) cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("seed_1ff.val", 32'(seed), 1);
      cyc(0, 0, 0, 0);

      add(0,1,100,0, 1,0,164); add(0,0,0,0, 1,0,164);
      add(0,1,500,0, 1,1,164); add(0,0,0,0, 1,0,164);
      add(0,1,110,0, 1,1,164); add(0,0,0,0, 1,0,164);
      add(0,1,140,0, 2,0,164); add(0,0,0,0, 2,0,164);
      add(0,0,0,1,   1,0,204); add(0,0,0,1,   0,0,0);
      add(0,0,0,1,   0,0,0);
      add(0,1,0,0,   1,0,64);  add(0,0,0,0,   1,0,64);
      add(0,1,40,0,  2,0,64);  add(0,0,0,0,   2,0,64);
      add(0,1,80,0,  3,0,64);  add(0,0,0,0,   3,0,64);
      add(0,1,120,0, 4,0,64);  add(0,0,0,0,   4,0,64);
      add(0,1,200,0, 4,1,64);  add(0,0,0,0,   4,0,64);
      add(0,1,200,1, 4,0,104); add(0,0,0,0,   4,0,104);
      add(0,0,0,1,   3,0,144); add(0,0,0,1,   2,0,184);
      add(0,1,300,0, 3,0,184); add(0,1,400,0, 3,0,184);
      add(0,1,0,0,   3,0,184); add(0,1,400,0, 3,0,184);
      add(0,1,100,0, 3,0,184); add(0,0,0,0,   3,0,184);
      add(0,1,400,0, 4,0,184); add(0,0,0,0,   4,0,184);
      foreach (tbl[i]) begin
         cyc(tbl[i].st, tbl[i].rt, tbl[i].r, tbl[i].p);
         chk($sformatf("vec%0d.count", i), 32'(count), tbl[i].c);
         chk($sformatf("vec%0d.reject", i), 32'(reject), tbl[i].rej);
         chk($sformatf("vec%0d.plat_x", i), 32'(plat_x), tbl[i].x);
      end

      // flush on mid-RUN start, last marker forgotten
      repeat (4) cyc(0, 0, 0, 1);
      cyc(0, 1, 200, 0); cyc(0, 0, 0, 0);
      cyc(0, 1, 100, 0); cyc(0, 0, 0, 0);
      cyc(0, 1, 10, 0);  cyc(0, 0, 0, 0);
      chk("flush.pre_count", 32'(count), 3);
      cyc(1, 0, 0, 1);
      chk("flush.count", 32'(count), 0);
      chk("flush.load", 32'(seed_load), 1);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 5, 0);
      chk("flush.near_ok", 32'(count), 1);
      chk("flush.near_x", 32'(plat_x), 69);
      chk("flush.near_rej", 32'(reject), 0);
      cyc(0, 0, 0, 0);

      // asynchronous reset between edges
      #2 Reset = 1'b1;
      #1 chk_zero("async_rst");
      @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      cyc(0, 1, 50, 0);
      chk("idle.no_sample", 32'(count), 0);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);

      rt = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 2) == 0) rt = ~rt;
         cyc($urandom_range(0, 149) == 0, rt,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 460)),
             $urandom_range(0, 4) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/platform_spawner.md
# platform_spawner

Consumer and seeder for the 9-bit platform LFSR. Loads the LFSR with a seed when the game starts. Samples one random value per rising edge of the LFSR's ready strobe and rejects values that are off-screen or too close to the previous platform. Queues accepted x-positions in a small show-ahead FIFO that the platform scroller pops whenever a platform leaves the bottom of the screen.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..8.
- MAX_X, 448: largest accepted raw sample, inclusive.
- X_OFFSET, 64: added to an accepted sample to form the screen x.
- MIN_SEP, 32: minimum |sample − last accepted sample|, in raw units.

Ports (one clock; reset is asynchronous and active-high):
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  game-start pulse; seeds or reseeds the LFSR.
- seed  out  9  seed value to the LFSR.
- seed_load  out  1  one-cycle pulse to the LFSR seed input.
- rnd  in  9  LFSR output.
- rnd_tick  in  1  LFSR ready strobe; level signal, high for several consecutive cycles.
- pop  in  1  consumer takes the head entry.
- plat_valid  out  1  FIFO non-empty.
- plat_x  out  10  head entry: X_OFFSET + sample; 0 when empty.
- count  out  4  FIFO occupancy, 0..DEPTH.
- reject  out  1  one-cycle pulse when a sampled value is discarded.

## Operation
- Entropy counter:
  - 9-bit free-running counter, +1 every cycle from reset, wraps 0x1FF→0x000.
- States and transitions:
  - IDLE: reset state; rnd_tick ignored; pop ignored when the FIFO is empty. start → SEED.
  - SEED (one cycle):
    - seed_load=1.
    - seed = counter value captured on the start cycle; a capture of 0x1FF is replaced by 0x001 (LFSR lock-up state).
    - FIFO flushed (count→0), last-accepted marker cleared, edge detector cleared.
    - Next state: RUN.
  - RUN: sampling active. start → SEED (reseed plus flush; any pop in that cycle is ignored).
- Tick edge:
  - tick_d registers rnd_tick (reset 0).
  - An edge is rnd_tick=1 and tick_d=0. Exactly one sample per high period.
- Acceptance on an edge in RUN, using rnd from the edge cycle. Accept iff all of:
  - rnd ≤ MAX_X;
  - no accepted sample since the last SEED, or |rnd − last| ≥ MIN_SEP (10-bit unsigned difference, no wrap);
  - count < DEPTH, or pop is high in the same cycle.
- Rejection:
  - Any failed condition gives reject=1 for that cycle. Nothing is written and last is unchanged.
- On accept:
  - Write X_OFFSET + rnd, zero-extended to 10 bits; X_OFFSET + MAX_X must be < 1024.
  - last ← rnd.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - pop while empty is ignored.
  - Push and pop in the same cycle: count unchanged, head advances.
  - Full with pop plus accept in the same cycle is legal.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The next start is required before any sampling.

## Timing
- Reset values:
  - outputs: seed=0, seed_load=0, plat_valid=0, plat_x=0, count=0, reject=0;
  - internal: state=IDLE, counter=0.
- start at cycle n:
  - seed_load=1 and seed valid in cycle n+1;
  - RUN from n+2;
  - seed holds its value until the next SEED.
- Edge at cycle n:
  - if accepted, the entry is visible (plat_valid, count, plat_x) in cycle n+1;
  - if rejected, reject=1 in cycle n+1.
- pop at cycle n: head and count update in cycle n+1. Output is show-ahead: plat_x always shows the current head.
- rnd_tick held high for 5 cycles produces exactly one sample. A new sample needs rnd_tick low for ≥1 cycle.

## Test plan
- Reset then start at counter=0x025:
  - seed_load pulses exactly one cycle later with seed=0x025;
  - count=0, plat_valid=0.
- start captured at counter=0x1FF → seed=0x001.
- In RUN, edges with rnd=100, then 500, then 110, then 140:
  - 100 accepted, plat_x=164;
  - 500 rejected (reject pulse, > MAX_X);
  - 110 rejected (separation);
  - 140 accepted, count=2.
- Four accepted samples (0, 40, 80, 120):
  - count=4;
  - fifth edge rnd=200 without pop → reject, count stays 4;
  - same edge with pop → accepted, count=4, plat_x=104.
- rnd_tick high for 5 cycles with rnd changing each cycle: only the first-cycle value is sampled; count increments by one.
- Three entries queued, then start mid-RUN:
  - FIFO flushes, count=0;
  - the next accepted sample ignores the old last value (rnd=5 after last=10 is accepted);
  - asynchronous Reset between clock edges clears all outputs immediately.
